fdivsqrt_issueq: RTL and testbench
==================================

Name: fdivsqrt_issueq

Overview:
- Small in-order request queue that sits directly upstream of the combined FP/integer divide-square-root unit.
- Accepts divide, sqrt, div and rem requests from the E-stage issue logic, holds them while the divider is busy, and launches exactly one operation at a time.
- Drives the divider's FDivStartE/IDivStartE and operand ports, and tracks the in-flight operation's tag so writeback can match the result.

Parameters:
- DEPTH, 4, number of queued requests; power of two, at least 2.
- TAGW, 5, width of the destination/ROB tag carried with each request.
- XLEN, 64, integer operand width.
- FMTBITS, 2, FP format field width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- FlushE  in  1  kill all queued and in-flight requests
- StallM  in  1  M-stage stall; blocks issue and completion
- EnqValid  in  1  request present
- EnqReady  out  1  queue can accept a request
- EnqSqrt  in  1  sqrt (1) or divide (0)
- EnqIntDiv  in  1  integer div/rem request
- EnqW64  in  1  RV64 W-form integer op
- EnqFunct3  in  3  funct3 of the op
- EnqFmt  in  FMTBITS  FP format
- EnqSrcA  in  XLEN  operand A
- EnqSrcB  in  XLEN  operand B
- EnqTag  in  TAGW  result tag
- FDivBusyE  in  1  divider busy
- FDivDoneE  in  1  divider result valid
- FDivStartE  out  1  FP start pulse
- IDivStartE  out  1  integer start pulse
- SqrtE  out  1  sqrt select for the issued op
- IntDivE  out  1  integer-op select for the issued op
- W64E  out  1  W-form select for the issued op
- Funct3E  out  3  funct3 of the issued op
- FmtE  out  FMTBITS  format of the issued op
- ForwardedSrcAE  out  XLEN  operand A of the issued op
- ForwardedSrcBE  out  XLEN  operand B of the issued op
- CplValid  out  1  completion pulse
- CplTag  out  TAGW  tag of the completing op
- Count  out  log2(DEPTH)+1  occupancy

Behaviour:
- Reset (asynchronous): head, tail and Count go to 0, InFlight to 0, and every output goes to 0. EnqReady is 1 once reset deasserts.
- Storage: circular FIFO with log2(DEPTH)-bit head and tail pointers that wrap naturally.
- EnqReady = (Count < DEPTH) and not FlushE. A dequeue in the same cycle does not free a slot for the enqueue (no full-bypass).
- Enqueue happens when EnqValid and EnqReady: the entry is written at tail and tail increments.
- Issue condition: Count > 0, not InFlight, not FDivBusyE, not StallM, not FlushE. On issue:
  - Start pulse is held for one cycle: FDivStartE = not IntDiv, IDivStartE = IntDiv.
  - SqrtE, IntDivE, W64E, Funct3E, FmtE and the operands present the head entry combinationally during the start cycle. After that they hold the last issued values until the next issue.
  - Head increments, InFlight is set, and the head tag is latched into InFlightTag.
- Simultaneous enqueue and issue: Count is unchanged.
- Minimum latency from enqueue to start is 1 cycle: an entry is visible at head only in the cycle after it is written.
- Completion: FDivDoneE, InFlight and not StallM together produce a 1-cycle CplValid with CplTag = InFlightTag, and InFlight clears.
  - A new issue may occur in the cycle after completion, not the same cycle.
  - FDivDoneE while not InFlight is ignored.
- FlushE: Count, head, tail and InFlight all clear on the next edge; CplValid is 0 that cycle.
  - A FlushE that coincides with FDivDoneE produces no completion.
  - An enqueue in a flush cycle is dropped.
- StallM: freezes issue and completion. Enqueue remains allowed.
- Count never exceeds DEPTH and never underflows; the bench asserts both.

Optional Feature:
- Macro: FDIVQ_BYPASS_EN.
- When defined and the queue is empty with the issue condition met, a valid enqueue is issued in the same cycle, straight from the Enq* inputs to the divider outputs. Nothing is written to the FIFO, and the latency is 0.
- Also when defined, EnqReady = (Count < DEPTH) or issue-this-cycle.
- When undefined: behaviour exactly as above, with a minimum latency of 1 cycle and no full-bypass.

Decomposition:
- Shared package holds:
  - typedef divreq_t: sqrt, intdiv, w64, funct3, fmt, srcA, srcB, tag.
  - FDIVQ_PTRW = $clog2(DEPTH).
- One natural sub-module, fdivq_fifo: a generic DEPTH-entry divreq_t storage with pointers and count. fdivsqrt_issueq adds the issue/InFlight/completion control around it.

Test Plan:
- Single FP divide: enqueue {sqrt=0, intdiv=0, tag=3} into an empty queue with an idle divider → FDivStartE=1 for exactly 1 cycle at cycle+1 (cycle+0 with bypass); FDivDoneE later → CplValid=1 with CplTag=3.
- Fill: enqueue 5 requests back-to-back while FDivBusyE=1 → EnqReady drops after the 4th and Count=4; the 5th is held off until a slot frees.
- Ordering: queue tags 1,2,3 (integer rem, sqrt, divide) → IDivStartE then FDivStartE (SqrtE=1) then FDivStartE (SqrtE=0), each only after the prior CplValid; CplTag sequence 1,2,3.
- Stall: StallM=1 in the cycle FDivDoneE arrives → no CplValid and no new issue; StallM drops and FDivDoneE is still high → CplValid next cycle.
- Flush mid-operation: 3 queued and 1 in flight, then FlushE → Count=0, no CplValid even if FDivDoneE coincides, EnqReady=1 the next cycle.
- Async reset while Count=2 and InFlight=1 → all outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/fdivsqrt_issueq_pkg.sv
// Shared types for the divide/sqrt issue queue. The optional FDIVQ_BYPASS_EN
// build lets an enqueue into an empty queue launch in the same cycle.
package fdivsqrt_issueq_pkg;

   localparam int FDIVQ_DEPTH   = 4;
   localparam int FDIVQ_TAGW    = 5;
   localparam int FDIVQ_XLEN    = 64;
   localparam int FDIVQ_FMTBITS = 2;
   localparam int FDIVQ_PTRW    = $clog2(FDIVQ_DEPTH);

   // One queued divider request; field widths track the package widths above.
   typedef struct packed {
      logic                     sqrt;
      logic                     intdiv;
      logic                     w64;
      logic [2:0]               funct3;
      logic [FDIVQ_FMTBITS-1:0] fmt;
      logic [FDIVQ_XLEN-1:0]    srcA;
      logic [FDIVQ_XLEN-1:0]    srcB;
      logic [FDIVQ_TAGW-1:0]    tag;
   } divreq_t;

endpackage

// File: rtl/fdivsqrt_issueq_fifo.sv
// Generic circular FIFO of divreq_t entries with wrapping pointers and an
// occupancy count; the caller guarantees no push when full and no pop when empty.
module fdivq_fifo
   import fdivsqrt_issueq_pkg::*;
#(
   parameter int DEPTH = FDIVQ_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  divreq_t                  pushData,
   input  logic                     pop,
   output divreq_t                  headData,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTRW = $clog2(DEPTH);

   divreq_t         mem [DEPTH];
   logic [PTRW-1:0] head;
   logic [PTRW-1:0] tail;

   // Pointer and count bookkeeping; a flush empties the queue without touching storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage needs no reset; only slots between head and tail are ever read.
   always_ff @(posedge clk) begin
      if (push && !clear) mem[tail] <= pushData;
   end

   assign headData = mem[head];

endmodule

// File: rtl/fdivsqrt_issueq.sv
// In-order request queue feeding the shared divide/sqrt unit: launches one op at
// a time and reports its tag on completion. Define FDIVQ_BYPASS_EN for 0-latency launch.
module fdivsqrt_issueq
   import fdivsqrt_issueq_pkg::*;
#(
   parameter int DEPTH   = FDIVQ_DEPTH,
   parameter int TAGW    = FDIVQ_TAGW,
   parameter int XLEN    = FDIVQ_XLEN,
   parameter int FMTBITS = FDIVQ_FMTBITS
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     FlushE,
   input  logic                     StallM,
   input  logic                     EnqValid,
   output logic                     EnqReady,
   input  logic                     EnqSqrt,
   input  logic                     EnqIntDiv,
   input  logic                     EnqW64,
   input  logic [2:0]               EnqFunct3,
   input  logic [FMTBITS-1:0]       EnqFmt,
   input  logic [XLEN-1:0]          EnqSrcA,
   input  logic [XLEN-1:0]          EnqSrcB,
   input  logic [TAGW-1:0]          EnqTag,
   input  logic                     FDivBusyE,
   input  logic                     FDivDoneE,
   output logic                     FDivStartE,
   output logic                     IDivStartE,
   output logic                     SqrtE,
   output logic                     IntDivE,
   output logic                     W64E,
   output logic [2:0]               Funct3E,
   output logic [FMTBITS-1:0]       FmtE,
   output logic [XLEN-1:0]          ForwardedSrcAE,
   output logic [XLEN-1:0]          ForwardedSrcBE,
   output logic                     CplValid,
   output logic [TAGW-1:0]          CplTag,
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int PTRW = $clog2(DEPTH);
   localparam logic [PTRW:0] FULLCOUNT = (PTRW+1)'(DEPTH);

   divreq_t        enqReq;
   divreq_t        headReq;
   divreq_t        issueReq;
   divreq_t        lastReq;
   logic [PTRW:0]  fifoCount;
   logic           inFlight;
   logic           canIssue;
   logic           pop;
   logic           push;
   logic           issue;
   logic           bypassIssue;
   logic           cpl;

   always_comb begin
      enqReq        = '0;
      enqReq.sqrt   = EnqSqrt;
      enqReq.intdiv = EnqIntDiv;
      enqReq.w64    = EnqW64;
      enqReq.funct3 = EnqFunct3;
      enqReq.fmt    = EnqFmt;
      enqReq.srcA   = EnqSrcA;
      enqReq.srcB   = EnqSrcB;
      enqReq.tag    = EnqTag;
   end

   // Reset gates issue so the divider controls drop the instant reset asserts.
   assign canIssue = !reset && !inFlight && !FDivBusyE && !StallM && !FlushE;
   assign pop      = canIssue && (fifoCount != '0);

`ifdef FDIVQ_BYPASS_EN
   assign bypassIssue = canIssue && (fifoCount == '0) && EnqValid;
   assign EnqReady    = !reset && !FlushE && ((fifoCount < FULLCOUNT) || pop || bypassIssue);
`else
   assign bypassIssue = 1'b0;
   assign EnqReady    = !reset && !FlushE && (fifoCount < FULLCOUNT);
`endif

   assign push     = EnqValid && EnqReady && !bypassIssue;
   assign issue    = pop || bypassIssue;
   assign issueReq = bypassIssue ? enqReq : headReq;

   fdivq_fifo #(.DEPTH(DEPTH)) fifo (
      .clk      (clk),
      .reset    (reset),
      .clear    (FlushE),
      .push     (push),
      .pushData (enqReq),
      .pop      (pop),
      .headData (headReq),
      .count    (fifoCount)
   );

   // lastReq keeps the launched op's fields steady between issues; its tag is the in-flight tag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lastReq  <= '0;
         inFlight <= 1'b0;
      end else begin
         if (issue) lastReq <= issueReq;
         if (FlushE || cpl)  inFlight <= 1'b0;
         else if (issue)     inFlight <= 1'b1;
      end
   end

   assign cpl        = FDivDoneE && inFlight && !StallM && !FlushE;
   assign CplValid   = cpl;
   assign CplTag     = lastReq.tag;
   assign Count      = fifoCount;

   assign FDivStartE     = issue && !issueReq.intdiv;
   assign IDivStartE     = issue &&  issueReq.intdiv;
   assign SqrtE          = issue ? issueReq.sqrt   : lastReq.sqrt;
   assign IntDivE        = issue ? issueReq.intdiv : lastReq.intdiv;
   assign W64E           = issue ? issueReq.w64    : lastReq.w64;
   assign Funct3E        = issue ? issueReq.funct3 : lastReq.funct3;
   assign FmtE           = issue ? issueReq.fmt    : lastReq.fmt;
   assign ForwardedSrcAE = issue ? issueReq.srcA   : lastReq.srcA;
   assign ForwardedSrcBE = issue ? issueReq.srcB   : lastReq.srcB;

endmodule

// File: tb/tb_fdivsqrt_issueq.sv
// Directed self-checking bench for fdivsqrt_issueq; expected completion tags are
// queued as requests are driven and popped when CplValid is seen.
module tb_fdivsqrt_issueq;

   localparam int DEPTH   = 4;
   localparam int TAGW    = 5;
   localparam int XLEN    = 64;
   localparam int FMTBITS = 2;

   logic                  clk;
   logic                  reset;
   logic                  FlushE, StallM;
   logic                  EnqValid, EnqReady;
   logic                  EnqSqrt, EnqIntDiv, EnqW64;
   logic [2:0]            EnqFunct3;
   logic [FMTBITS-1:0]    EnqFmt;
   logic [XLEN-1:0]       EnqSrcA, EnqSrcB;
   logic [TAGW-1:0]       EnqTag;
   logic                  FDivBusyE, FDivDoneE;
   logic                  FDivStartE, IDivStartE;
   logic                  SqrtE, IntDivE, W64E;
   logic [2:0]            Funct3E;
   logic [FMTBITS-1:0]    FmtE;
   logic [XLEN-1:0]       ForwardedSrcAE, ForwardedSrcBE;
   logic                  CplValid;
   logic [TAGW-1:0]       CplTag;
   logic [$clog2(DEPTH):0] Count;

   int checks = 0;
   int errors = 0;
   int sb[$];

   fdivsqrt_issueq #(.DEPTH(DEPTH), .TAGW(TAGW), .XLEN(XLEN), .FMTBITS(FMTBITS)) dut (
      .clk(clk), .reset(reset), .FlushE(FlushE), .StallM(StallM),
      .EnqValid(EnqValid), .EnqReady(EnqReady), .EnqSqrt(EnqSqrt),
      .EnqIntDiv(EnqIntDiv), .EnqW64(EnqW64), .EnqFunct3(EnqFunct3),
      .EnqFmt(EnqFmt), .EnqSrcA(EnqSrcA), .EnqSrcB(EnqSrcB), .EnqTag(EnqTag),
      .FDivBusyE(FDivBusyE), .FDivDoneE(FDivDoneE),
      .FDivStartE(FDivStartE), .IDivStartE(IDivStartE), .SqrtE(SqrtE),
      .IntDivE(IntDivE), .W64E(W64E), .Funct3E(Funct3E), .FmtE(FmtE),
      .ForwardedSrcAE(ForwardedSrcAE), .ForwardedSrcBE(ForwardedSrcBE),
      .CplValid(CplValid), .CplTag(CplTag), .Count(Count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [63:0] srcOf(input logic [4:0] t, input bit b);
      return b ? {32'hB0B0_0000, 27'd0, t} : {32'hA0A0_0000, 27'd0, t};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic sqrt, input logic intdiv,
                                input logic [2:0] f3, input logic [4:0] tag);
      EnqValid  = valid;
      EnqSqrt   = sqrt;
      EnqIntDiv = intdiv;
      EnqW64    = intdiv;
      EnqFunct3 = f3;
      EnqFmt    = 2'(tag);
      EnqSrcA   = srcOf(tag, 1'b0);
      EnqSrcB   = srcOf(tag, 1'b1);
      EnqTag    = tag;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Checks a launch in the current cycle against the request the bench queued.
   task automatic checkStart(input logic fp, input logic sqrt, input logic [2:0] f3, input logic [4:0] tag);
      @(negedge clk);
      checkOutput("fdivStart", FDivStartE, fp);
      checkOutput("idivStart", IDivStartE, !fp);
      checkOutput("sqrtE", SqrtE, sqrt);
      checkOutput("intDivW64", {IntDivE, W64E}, {!fp, !fp});
      checkOutput("funct3E", Funct3E, f3);
      checkOutput("fmtE", FmtE, 2'(tag));
      checkOutput("srcA", ForwardedSrcAE, srcOf(tag, 1'b0));
      checkOutput("srcB", ForwardedSrcBE, srcOf(tag, 1'b1));
   endtask

   task automatic completeOp();
      FDivDoneE = 1'b1;
      @(negedge clk);
      checkOutput("cplValid", CplValid, 1'b1);
      checkOutput("noIssueAtCpl", {FDivStartE, IDivStartE}, 2'b00);
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("[TB] FAIL cplTag observed=%0d expected=none (scoreboard empty)", CplTag);
      end else begin
         checkOutput("cplTag", CplTag, 64'(sb.pop_front()));
      end
      nextCycle();
      FDivDoneE = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         checks++;
         assert (Count <= DEPTH)
         else begin
            errors++;
            $error("[TB] FAIL countBound observed=%0d expected<=%0d", Count, DEPTH);
         end
      end
   end

   initial begin
      reset = 1'b1; FlushE = 1'b0; StallM = 1'b0; FDivBusyE = 1'b0; FDivDoneE = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
      #2;
      checkOutput("resetEnqReady", EnqReady, 1'b0);
      checkOutput("resetCount", Count, 0);
      checkOutput("resetStarts", {FDivStartE, IDivStartE, CplValid}, 3'b000);
      #10 reset = 1'b0;
      @(negedge clk);
      checkOutput("postResetReady", EnqReady, 1'b1);
      checkOutput("postResetCount", Count, 0);
      nextCycle();

      // Single FP divide, tag 3
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 5'd3);
      sb.push_back(3);
`ifdef FDIVQ_BYPASS_EN
      checkStart(1'b1, 1'b0, 3'd0, 5'd3);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
      @(negedge clk);
      checkOutput("startOneCycle", FDivStartE, 1'b0);
`else
      @(negedge clk);
      checkOutput("noStartSameCycle", FDivStartE, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
      checkStart(1'b1, 1'b0, 3'd0, 5'd3);
`endif
      nextCycle();
      @(negedge clk);
      checkOutput("startDropped", FDivStartE, 1'b0);
      checkOutput("holdSrcA", ForwardedSrcAE, srcOf(5'd3, 1'b0));
      nextCycle();
      FDivBusyE = 1'b1;
      nextCycle();
      nextCycle();
      FDivBusyE = 1'b0;
      completeOp();
      @(negedge clk);
      checkOutput("cplOneCycle", CplValid, 1'b0);
      nextCycle();

      // Fill while the divider is busy
      FDivBusyE = 1'b1;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 5'(10 + i));
         @(negedge clk);
         checkOutput("fillReady", EnqReady, (i < 4));
         if (i < 4) sb.push_back(10 + i);
         nextCycle();
      end
      @(negedge clk);
      checkOutput("fillCount", Count, 4);
      checkOutput("fullNotReady", EnqReady, 1'b0);
      nextCycle();
      FDivBusyE = 1'b0;
      checkStart(1'b1, 1'b0, 3'd0, 5'd10);
`ifdef FDIVQ_BYPASS_EN
      checkOutput("readyOnIssue", EnqReady, 1'b1);
      sb.push_back(14);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
`else
      checkOutput("noFullBypass", EnqReady, 1'b0);
      nextCycle();
      @(negedge clk);
      checkOutput("readyAfterFree", EnqReady, 1'b1);
      sb.push_back(14);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
`endif
      @(negedge clk);
      checkOutput("refillCount", Count, 4);
      nextCycle();
      completeOp();
      for (int k = 11; k <= 14; k++) begin
         checkStart(1'b1, 1'b0, 3'd0, 5'(k));
         nextCycle();
         completeOp();
      end
      @(negedge clk);
      checkOutput("drainedCount", Count, 0);
      nextCycle();

      // Ordering: integer rem, sqrt, divide
      FDivBusyE = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b1, 3'b110, 5'd1); sb.push_back(1); nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 5'd2); sb.push_back(2); nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 5'd3); sb.push_back(3); nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
      FDivBusyE = 1'b0;
      checkStart(1'b0, 1'b0, 3'b110, 5'd1);
      nextCycle();
      completeOp();
      checkStart(1'b1, 1'b1, 3'b000, 5'd2);
      nextCycle();
      completeOp();
      checkStart(1'b1, 1'b0, 3'b000, 5'd3);
      nextCycle();
      completeOp();

      // Stall at completion
      FDivBusyE = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 5'd7); sb.push_back(7); nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
      FDivBusyE = 1'b0;
      checkStart(1'b1, 1'b0, 3'd0, 5'd7);
      nextCycle();
      StallM = 1'b1; FDivDoneE = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 5'd8); sb.push_back(8);
      @(negedge clk);
      checkOutput("stallNoCpl", CplValid, 1'b0);
      checkOutput("stallNoIssue", {FDivStartE, IDivStartE}, 2'b00);
      checkOutput("stallEnqReady", EnqReady, 1'b1);
      nextCycle();
      StallM = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
      @(negedge clk);
      checkOutput("unstallCpl", CplValid, 1'b1);
      checkOutput("unstallTag", CplTag, 64'(sb.pop_front()));
      nextCycle();
      FDivDoneE = 1'b0;
      checkStart(1'b1, 1'b1, 3'd0, 5'd8);
      nextCycle();
      completeOp();

      // Flush with three queued and one in flight
      FDivBusyE = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 5'd20); nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
      FDivBusyE = 1'b0;
      checkStart(1'b1, 1'b0, 3'd0, 5'd20);
      nextCycle();
      FDivBusyE = 1'b1;
      for (int t = 21; t <= 23; t++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 5'(t));
         nextCycle();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
      @(negedge clk);
      checkOutput("preFlushCount", Count, 3);
      nextCycle();
      FlushE = 1'b1; FDivDoneE = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 5'd24);
      @(negedge clk);
      checkOutput("flushNoCpl", CplValid, 1'b0);
      checkOutput("flushNotReady", EnqReady, 1'b0);
      nextCycle();
      FlushE = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
      @(negedge clk);
      checkOutput("flushCount", Count, 0);
      checkOutput("flushReady", EnqReady, 1'b1);
      checkOutput("doneIgnored", CplValid, 1'b0);
      nextCycle();
      FDivDoneE = 1'b0; FDivBusyE = 1'b0;
      @(negedge clk);
      checkOutput("flushDropped", {FDivStartE, IDivStartE}, 2'b00);
      nextCycle();

      // Asynchronous reset with two queued and one in flight
      FDivBusyE = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd5, 5'd30); nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 5'd31); nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
      FDivBusyE = 1'b0;
      checkStart(1'b1, 1'b1, 3'd5, 5'd30);
      nextCycle();
      FDivBusyE = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 5'd32); nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
      FDivDoneE = 1'b1;
      @(negedge clk);
      checkOutput("preResetCount", Count, 2);
      checkOutput("preResetCpl", {CplValid, CplTag}, {1'b1, 5'd30});
      #2 reset = 1'b1;
      #1;
      checkOutput("asyncCount", Count, 0);
      checkOutput("asyncReady", EnqReady, 1'b0);
      checkOutput("asyncCpl", {CplValid, CplTag}, 0);
      checkOutput("asyncCtl", {SqrtE, IntDivE, W64E, Funct3E, FmtE, FDivStartE, IDivStartE}, 0);
      checkOutput("asyncSrcA", ForwardedSrcAE, 0);
      checkOutput("asyncSrcB", ForwardedSrcBE, 0);
      checkOutput("scoreboardEmpty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
